grid_mem_arbiter: RTL and testbench

// - Shares one single-port grid memory between NUM_REQ placement engines running in parallel.
// - Round-robin arbitration, one access per cycle, valid/ready request side, pulsed read responses.
// - Built-in clear engine fills every cell with the empty marker (all ones, -1):
//   - automatically after reset;
//   - on demand between placement runs.

---
 rtl/grid_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_grid_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter: round-robin sharing of one single-port grid memory
// between NUM_REQ placement engines, plus an all-ones clear sweep engine.
// Ports: clk, reset (sync, active-high); clear_start / clear_busy;
//   req_valid, req_we, req_addr, req_wdata (packed per requester), req_ready;
//   rsp_valid (per requester), rsp_rdata (shared);
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata (1-cycle read latency).
// Optional macro GRID_ARB_CONFLICT_CNT_EN adds output conflict_cnt[15:0].
module grid_mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_start,
    output logic                      clear_busy,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
`ifdef GRID_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]               conflict_cnt
`endif
);

    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW1 = PW + 1;

    typedef enum logic {CLEAR = 1'b0, ARB = 1'b1} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_addr;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       grant_idx;
    logic [PW-1:0]       cand;
    logic [PW1-1:0]      idx;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [NUM_REQ-1:0]  rd_pend;
    logic [DATA_W-1:0]   rdata_q;
    logic                found;
    logic                xfer;
    logic                clr_last;

    assign clr_last = (clr_addr == ADDR_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_last) state_nxt = ARB;
            ARB:     if (clear_start) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW1'(rr_ptr) + PW1'(i);
            if (idx >= PW1'(NUM_REQ)) idx = idx - PW1'(NUM_REQ);
            cand = idx[PW-1:0];
            if (!found && req_valid[cand]) begin
                found          = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
            end
        end
    end

    // Output logic: a clear request blocks the grant in the same cycle
    always_comb begin
        req_ready = '0;
        if (state == ARB && !clear_start) req_ready = grant_oh;
    end

    assign xfer = |(req_valid & req_ready);

    // Read data is presented the cycle it leaves the memory and held after
    assign rsp_rdata = (|rsp_valid) ? mem_rdata : rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_addr   <= '0;
            rr_ptr     <= '0;
            clear_busy <= 1'b1;
            rd_pend    <= '0;
            rsp_valid  <= '0;
            rdata_q    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            rsp_valid <= rd_pend;
            rd_pend   <= '0;
            if (|rsp_valid) rdata_q <= mem_rdata;
            if (state == CLEAR) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= clr_addr;
                mem_wdata <= '1;
                if (clr_last) begin
                    clr_addr   <= '0;
                    clear_busy <= 1'b0;
                end else begin
                    clr_addr <= clr_addr + 1'b1;
                end
            end else if (xfer) begin
                mem_en    <= 1'b1;
                mem_we    <= req_we[grant_idx];
                mem_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                mem_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
                rr_ptr    <= (grant_idx == PW'(NUM_REQ - 1)) ? '0
                                                             : grant_idx + 1'b1;
                if (!req_we[grant_idx]) rd_pend <= grant_oh;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                if (clear_start) begin
                    clear_busy <= 1'b1;
                    clr_addr   <= '0;
                end
            end
        end
    end

`ifdef GRID_ARB_CONFLICT_CNT_EN
    logic multi;
    assign multi = |(req_valid & (req_valid - 1'b1));

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (state == ARB) begin
            if (clear_start)
                conflict_cnt <= '0;
            else if (multi && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// tb_grid_mem_arbiter: randomized + directed bench for grid_mem_arbiter
// with a behavioural grid model and a response scoreboard.
module tb_grid_mem_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int CELLS   = 2 ** ADDR_W;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      clear_start;
    logic                      clear_busy;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
`ifdef GRID_ARB_CONFLICT_CNT_EN
    logic [15:0]               conflict_cnt;
`endif

    always #5 clk = ~clk;

    grid_mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef GRID_ARB_CONFLICT_CNT_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    // Single-port synchronous memory, one-cycle read latency
    logic [DATA_W-1:0] ram [CELLS];
    logic [DATA_W-1:0] ram_q;
    bit                ram_ok;
    assign mem_rdata = ram_q;

    always @(posedge clk) begin
        if (!ram_ok) begin
            for (int i = 0; i < CELLS; i++) ram[i] <= 8'h5A;
            ram_q  <= '0;
            ram_ok <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t              q[$];
    int                grant_log[$];
    logic [DATA_W-1:0] ref_grid [CELLS];
    bit                ref_ok;
    bit                armed;
    bit                rst_q;
    int                cyc = 0;
    int                blk;
    int                rr;
    bit                exp_en, exp_we, exp_clr;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] last_rd;
    logic [NUM_REQ-1:0] acc;
    logic [15:0]       mcnt;

    always @(posedge clk) begin
        rst_q <= reset;
        cyc   <= cyc + 1;
    end

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] er;
        exp_t e;
        int g;
        int c;
        if (rst_q) armed = 1'b1;
        acc = '0;
        if (armed) begin
            if (rst_q) begin
                if (!ref_ok) begin
                    for (int i = 0; i < CELLS; i++) ref_grid[i] = 8'h5A;
                    ref_ok = 1'b1;
                end
                q.delete();
                blk = DEPTH; rr = 0; mcnt = '0; last_rd = '0;
                chk(!mem_en && !mem_we && mem_addr == 0 && mem_wdata == 0,
                    "reset_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
                chk(rsp_valid == 0 && rsp_rdata == 0, "reset_rsp",
                    {rsp_valid, rsp_rdata}, 0);
            end else begin
                if (exp_en) begin
                    chk(mem_en && mem_we == exp_we && mem_addr == exp_addr &&
                        mem_wdata == exp_data, "mem_op",
                        {mem_en, mem_we, mem_addr, mem_wdata},
                        {1'b1, exp_we, exp_addr, exp_data});
                    if (exp_clr) ref_grid[exp_addr] = '1;
                end else begin
                    chk(!mem_en && !mem_we, "mem_idle", {mem_en, mem_we}, 0);
                end
                if (rsp_valid != 0) begin
                    if (q.size() == 0) begin
                        chk(1'b0, "rsp_unexpected", rsp_valid, 0);
                        last_rd = rsp_rdata;
                    end else begin
                        e = q.pop_front();
                        chk(rsp_valid == NUM_REQ'(1 << e.id) &&
                            rsp_rdata == e.data, "rsp_data",
                            {rsp_valid, rsp_rdata}, {NUM_REQ'(1 << e.id), e.data});
                        chk(cyc == e.cyc, "rsp_time", cyc, e.cyc);
                        last_rd = e.data;
                    end
                end else begin
                    chk(rsp_rdata == last_rd, "rsp_hold", rsp_rdata, last_rd);
                    if (q.size() != 0 && q[0].cyc <= cyc) begin
                        chk(1'b0, "rsp_missing", 0, q[0].id);
                        void'(q.pop_front());
                    end
                end
            end
            chk(clear_busy == (blk > 0), "clear_busy", clear_busy, blk > 0);
`ifdef GRID_ARB_CONFLICT_CNT_EN
            chk(conflict_cnt == mcnt, "conflict_cnt", conflict_cnt, mcnt);
            if (blk == 0) begin
                if (clear_start) mcnt = '0;
                else if ($countones(req_valid) >= 2 && mcnt != 16'hFFFF)
                    mcnt = mcnt + 16'd1;
            end
`endif
            er = '0;
            g  = -1;
            if (blk == 0 && !clear_start) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (rr + k) % NUM_REQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            chk(req_ready == er, "req_ready", req_ready, er);
            acc = req_valid & req_ready;
            exp_en = 1'b0; exp_we = 1'b0; exp_clr = 1'b0;
            if (blk > 0) begin
                exp_en = 1'b1; exp_we = 1'b1; exp_clr = 1'b1;
                exp_addr = ADDR_W'(DEPTH - blk);
                exp_data = '1;
                blk--;
            end else if (clear_start) begin
                blk = DEPTH;
            end else if (g >= 0) begin
                exp_en   = 1'b1;
                exp_we   = req_we[g];
                exp_addr = req_addr[g*ADDR_W +: ADDR_W];
                exp_data = req_wdata[g*DATA_W +: DATA_W];
                if (exp_we) ref_grid[exp_addr] = exp_data;
                else q.push_back('{g, ref_grid[exp_addr], cyc + 2});
                rr = (g + 1) % NUM_REQ;
                grant_log.push_back(g);
            end
        end
    end

    // Stimulus helpers
    task automatic set_op(input int r, input bit v, input bit we,
                          input int addr, input int data);
        req_valid[r] = v;
        req_we[r]    = we;
        req_addr[r*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
        req_wdata[r*DATA_W +: DATA_W] = DATA_W'(data);
    endtask

    task automatic new_op(input int r, input bit v);
        set_op(r, v, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
               $urandom_range(0, 255));
    endtask

    task automatic run(input int n, input logic [NUM_REQ-1:0] mask,
                       input int pct, input int pclr);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            clear_start = ($urandom_range(0, 99) < pclr);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!mask[r]) req_valid[r] = 1'b0;
                else if (!req_valid[r] || acc[r])
                    new_op(r, $urandom_range(0, 99) < pct);
            end
        end
    endtask

    task automatic wait_acc(input int r);
        bit ok = 1'b0;
        int i  = 0;
        while (i < 50 && !ok) begin
            @(posedge clk);
            ok = acc[r];
            i++;
        end
        #1;
        if (!ok) chk(1'b0, "acc_timeout", r, 1);
    endtask

    task automatic wait_idle();
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (clear_busy && i < 60);
        if (clear_busy) chk(1'b0, "busy_timeout", clear_busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int c0;
        reset = 1'b1; clear_start = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Both requesters held valid from the first sweep cycle
        grant_log.delete();
        new_op(0, 1'b1); new_op(1, 1'b1);
        n = 0;
        while (grant_log.size() < 6 && n < 60) begin
            run(1, 2'b11, 100, 0);
            n++;
        end
        chk(grant_log.size() >= 6, "alt_count", grant_log.size(), 6);
        if (grant_log.size() >= 6)
            for (int i = 0; i < 6; i++)
                chk(grant_log[i] == i % 2, "alt_grant", grant_log[i], i % 2);
        req_valid = '0;
        repeat (3) @(posedge clk); #1;

        // Write then read-back of the same cell on req0
        set_op(0, 1'b1, 1'b1, 5, 8'h03);
        wait_acc(0);
        set_op(0, 1'b1, 1'b0, 5, 0);
        wait_acc(0);
        req_valid = '0;
        c0 = cyc;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == 0 && n < 10);
        chk(rsp_valid == 2'b01 && rsp_rdata == 8'h03, "raw_rsp",
            {rsp_valid, rsp_rdata}, {2'b01, 8'h03});
        chk(cyc == c0 + 1, "raw_latency", cyc - c0, 1);
        @(posedge clk); #1;

        // Random traffic with occasional clear requests
        run(300, 2'b11, 60, 2);
        req_valid = '0; clear_start = 1'b0;
        wait_idle();

        // Clear request with both valid and a read in flight
        set_op(0, 1'b1, 1'b0, 3, 0);
        wait_acc(0);
        grant_log.delete();
        new_op(0, 1'b1); new_op(1, 1'b1);
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        n = 0;
        @(negedge clk);
        while (clear_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk(n == DEPTH, "sweep_len", n, DEPTH);
        n = 0;
        while (grant_log.size() == 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        chk(grant_log.size() > 0 && grant_log[0] == 1, "resume_rr",
            grant_log.size() > 0 ? grant_log[0] : -1, 1);
        #1 req_valid = '0;
        repeat (3) @(posedge clk); #1;

        // Reset pulsed in the middle of a sweep
        clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_en && mem_we && mem_addr == 7) && n < 40);
        chk(mem_addr == 7, "sweep_at7", mem_addr, 7);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(mem_en && mem_we && mem_addr == 0, "restart_a0", mem_addr, 0);
        @(negedge clk);
        chk(mem_en && mem_we && mem_addr == 1, "restart_a1", mem_addr, 1);
        wait_idle();

        // Reset while a read response is pending
        set_op(0, 1'b1, 1'b0, 2, 0);
        wait_acc(0);
        req_valid = '0;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid != 0) n++;
        end
        chk(n == 0, "dropped_rsp", n, 0);
        wait_idle();

`ifdef GRID_ARB_CONFLICT_CNT_EN
        clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        wait_idle();
        run(10, 2'b11, 100, 0);
        run(3, 2'b01, 100, 0);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk(conflict_cnt == 16'd10, "conflict_10", conflict_cnt, 10);
        @(posedge clk); #1 clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        @(negedge clk);
        chk(conflict_cnt == 16'd0, "conflict_clr", conflict_cnt, 0);
        wait_idle();
`endif

        run(150, 2'b11, 80, 0);
        req_valid = '0;
        repeat (5) @(posedge clk);
        chk(q.size() == 0, "drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
